// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-to-decode bundle: instruction-memory port, decode handshake and branch redirect.
// master = fetch stage, slave = surrounding pipeline / memory model.
interface fetch_prefetch_queue_if #(
   parameter int unsigned DEPTH = 4
);
   logic                     pc_src;
   logic [31:0]              add_res;
   logic [31:0]              imem_addr;
   logic [31:0]              imem_inst;
   logic                     d_stall;
   logic                     d_valid;
   logic [31:0]              d_inst;
   logic [31:0]              d_pc;
   logic [$clog2(DEPTH):0]   q_count;

   modport master (
      input  pc_src, add_res, imem_inst, d_stall,
      output imem_addr, d_valid, d_inst, d_pc, q_count
   );

   modport slave (
      output pc_src, add_res, imem_inst, d_stall,
      input  imem_addr, d_valid, d_inst, d_pc, q_count
   );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch with a DEPTH-entry prefetch queue of {PC+4, inst} feeding decode.
// Define FETCH_BYPASS_EN to present the fetched instruction directly when the queue is empty.
module fetch_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic                    clk,
   input logic                    rst,
   fetch_prefetch_queue_if.master bus
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [31:0]     pc_q;
   logic [31:0]     inst_mem [DEPTH];
   logic [31:0]     pc4_mem  [DEPTH];
   logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0] count_q;

   logic [31:0] pc_plus4;
   logic        empty, full, bypass, pop, push, wr_en, rd_en;

   assign pc_plus4 = pc_q + 32'd4;
   assign empty    = (count_q == '0);
   assign full     = (count_q == CntW'(DEPTH));

`ifdef FETCH_BYPASS_EN
   assign bypass = empty & ~bus.pc_src;
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      bus.d_valid = 1'b0;
      bus.d_inst  = '0;
      bus.d_pc    = '0;
      if (!empty) begin
         bus.d_valid = 1'b1;
         bus.d_inst  = inst_mem[rd_ptr_q];
         bus.d_pc    = pc4_mem[rd_ptr_q];
      end else if (bypass) begin
         bus.d_valid = 1'b1;
         bus.d_inst  = bus.imem_inst;
         bus.d_pc    = pc_plus4;
      end
   end

   assign bus.imem_addr = pc_q;
   assign bus.q_count   = count_q;

   assign pop   = bus.d_valid & ~bus.d_stall;
   assign push  = ~bus.pc_src & (~full | pop);
   // A bypassed instruction consumed this cycle never occupies a slot.
   assign wr_en = push & ~(bypass & pop);
   assign rd_en = pop & ~empty;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         inst_mem[wr_ptr_q] <= bus.imem_inst;
         pc4_mem[wr_ptr_q]  <= pc_plus4;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (bus.pc_src) begin
         pc_q     <= {bus.add_res[31:2], 2'b00};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push)  pc_q     <= pc_plus4;
         if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Instruction-fetch stage with prefetch buffer. Drives the instruction-memory address, queues fetched instructions with their PC+4, and presents them to the decode input register.
- Decouples fetch from decode back-pressure (stall) and squashes queued instructions when a taken branch resolves (pc_src/add_res from the memory stage).
- Replaces the free-running PC and bare IF/ID path so hazard stalls can be inserted later without losing instructions.

Parameters:
- DEPTH, 4, queue entries; power of two, >=2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; word aligned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- pc_src  in  1  taken-branch redirect, sampled on the clock edge.
- add_res  in  32  branch target; bits [1:0] ignored (forced 0).
- imem_addr  out  32  instruction-memory address = current PC (combinational from PC reg).
- imem_inst  in  32  instruction at imem_addr, combinational same-cycle read.
- d_stall  in  1  decode cannot accept this cycle.
- d_valid  out  1  d_inst/d_pc hold a real instruction.
- d_inst  out  32  head instruction; 32'h0 (nop) when d_valid=0.
- d_pc  out  32  head PC+4; 0 when d_valid=0.
- q_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=1 at edge): PC<=RESET_PC, queue emptied, q_count=0, d_valid=0, d_inst=0, d_pc=0. Reset has priority over pc_src, push and pop. Mid-operation reset discards all entries.
- pop = d_valid & !d_stall. push = !pc_src & (q_count<DEPTH | pop).
- Push at edge: entry {PC+4, imem_inst} written at tail, PC<=PC+4 (32-bit modulo wrap, 32'hFFFF_FFFC -> 0).
- No push (full, no pop): PC and imem_addr hold.
- Pop at edge: head advances. Push+pop same edge: q_count unchanged. Full+pop+push is legal.
- pc_src=1 at edge (flush): all entries discarded, q_count<=0, PC<={add_res[31:2],2'b00}. The instruction fetched that cycle is dropped. Pop is irrelevant. Flush overrides stall.
- Output path: d_valid=(q_count!=0); d_inst/d_pc combinational from head entry, else 0.
- Latency: instruction fetched in cycle N is visible at outputs in cycle N+1. Target fetched first in cycle after pc_src, visible one cycle later.
- While d_stall=1 and d_valid=1: d_inst/d_pc stable until popped or flushed.
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH; q_count is a separate counter, never exceeds DEPTH or underflows.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when q_count==0 and !pc_src, imem_inst and PC+4 drive d_inst/d_pc directly with d_valid=1 in the fetch cycle (zero latency).
  - If also !d_stall, the instruction is consumed without entering the queue; PC advances and q_count stays 0.
  - If d_stall, the instruction is pushed normally.
- Undefined: fixed one-cycle latency as above; outputs come only from the queue.

Test Plan:
- Reset: hold rst 2 cycles with imem_inst=32'h200a0005 -> d_valid=0, d_inst=0, d_pc=0, q_count=0, imem_addr=0. First cycle after release: q_count 0->1, next cycle d_inst=32'h200a0005, d_pc=4.
- Straight line, d_stall=0, program 0x0,0x200a0005,0x200b0007 -> d_pc sequence 4,8,12 on consecutive cycles; q_count steady at 1 (bypass off).
- d_stall=1 from cycle 1 -> q_count reaches 4 after 4 fetches; imem_addr freezes at 16; d_inst stays mem[0]. Release stall -> one pop per cycle, pushes resume the same edge, no instruction lost or duplicated.
- Flush: q_count=3, pc_src=1, add_res=32'h0000_0022 -> next cycle q_count=0, d_valid=0, imem_addr=32'h20; following cycle d_pc=32'h24.
- Simultaneous pc_src=1, d_stall=1, queue full -> flush wins, q_count=0, PC=target. Rst=1 together with pc_src=1 -> PC=RESET_PC.
- Wrap: RESET_PC=32'hFFFF_FFFC -> first d_pc=0, next imem_addr=0. With FETCH_BYPASS_EN, empty queue and d_stall=0 -> d_inst equals imem_inst in the same cycle and q_count stays 0.
